// File: rtl/led_pattern_if.sv
// Host-side bundle for the LED pattern generator: mode request/load in, LED drive and tick out.
interface led_pattern_if #(
    parameter int NUM_LEDS = 4
) ();
    logic [1:0]          mode_in;
    logic                mode_load_in;
    logic [NUM_LEDS-1:0] led_out;
    logic                tick_out;

    modport master (
        output mode_in,
        output mode_load_in,
        input  led_out,
        input  tick_out
    );

    modport slave (
        input  mode_in,
        input  mode_load_in,
        output led_out,
        output tick_out
    );
endinterface

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: prescaled time base driving OFF / COUNT / CHASE / BREATHE.
//
// state        | meaning
// MODE_OFF     | all LEDs dark, counters keep running
// MODE_COUNT   | binary count, advances once per step
// MODE_CHASE   | one-hot rotate left, advances once per step
// MODE_BREATHE | PWM on all LEDs, duty ramps up/down once per tick
module led_pattern_gen #(
    parameter int NUM_LEDS   = 4,
    parameter int PRESCALE   = 12000,
    parameter int STEP_TICKS = 250,
    parameter int PWM_BITS   = 8
) (
    input logic       clk_in,
    input logic       rst_n_in,
    led_pattern_if.slave bus
);
    localparam int PW = $clog2(PRESCALE);
    localparam int SW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
    localparam logic [PW-1:0]       PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [SW-1:0]       STEP_LAST  = SW'(STEP_TICKS - 1);
    localparam logic [PWM_BITS-1:0] DUTY_MAX   = '1;
    localparam logic [NUM_LEDS-1:0] ONE_HOT0   = NUM_LEDS'(1);

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_COUNT   = 2'd1,
        MODE_CHASE   = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_t;

    mode_t               mode, mode_nxt;
    logic [PW-1:0]       presc, presc_nxt;
    logic [SW-1:0]       step_cnt, step_cnt_nxt;
    logic [NUM_LEDS-1:0] pattern, pattern_nxt;
    logic [PWM_BITS-1:0] pwm_cnt, pwm_cnt_nxt;
    logic [PWM_BITS-1:0] duty, duty_nxt;
    logic                dir_down, dir_down_nxt;
    logic [NUM_LEDS-1:0] led, led_nxt;
    logic                tick, step;

    assign tick = (presc == PRESC_LAST);
    assign step = tick && (step_cnt == STEP_LAST);

    assign bus.tick_out = tick;
    assign bus.led_out  = led;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            mode     <= MODE_OFF;
            presc    <= '0;
            step_cnt <= '0;
            pattern  <= '0;
            pwm_cnt  <= '0;
            duty     <= '0;
            dir_down <= 1'b0;
            led      <= '0;
        end else begin
            mode     <= mode_nxt;
            presc    <= presc_nxt;
            step_cnt <= step_cnt_nxt;
            pattern  <= pattern_nxt;
            pwm_cnt  <= pwm_cnt_nxt;
            duty     <= duty_nxt;
            dir_down <= dir_down_nxt;
            led      <= led_nxt;
        end
    end

    always_comb begin
        mode_nxt     = mode;
        presc_nxt    = tick ? '0 : presc + 1'b1;
        step_cnt_nxt = step_cnt;
        pattern_nxt  = pattern;
        pwm_cnt_nxt  = pwm_cnt + 1'b1;
        duty_nxt     = duty;
        dir_down_nxt = dir_down;
        led_nxt      = '0;

        if (tick) begin
            step_cnt_nxt = (step_cnt == STEP_LAST) ? '0 : step_cnt + 1'b1;
        end

        case (mode)
            MODE_COUNT: begin
                if (step) pattern_nxt = pattern + 1'b1;
                led_nxt = pattern_nxt;
            end
            MODE_CHASE: begin
                if (step) pattern_nxt = {pattern[NUM_LEDS-2:0], pattern[NUM_LEDS-1]};
                led_nxt = pattern_nxt;
            end
            MODE_BREATHE: begin
                // Direction flips on the edge that lands on an endpoint, so each endpoint lasts one tick.
                if (tick) begin
                    if (!dir_down) begin
                        duty_nxt = duty + 1'b1;
                        if (duty_nxt == DUTY_MAX) dir_down_nxt = 1'b1;
                    end else begin
                        duty_nxt = duty - 1'b1;
                        if (duty_nxt == '0) dir_down_nxt = 1'b0;
                    end
                end
                led_nxt = {NUM_LEDS{pwm_cnt < duty}};
            end
            default: led_nxt = '0;
        endcase

        // A load wins over any tick/step on the same edge; OFF and BREATHE start with a zero pattern.
        if (bus.mode_load_in) begin
            mode_nxt     = mode_t'(bus.mode_in);
            presc_nxt    = '0;
            step_cnt_nxt = '0;
            pwm_cnt_nxt  = '0;
            duty_nxt     = '0;
            dir_down_nxt = 1'b0;
            pattern_nxt  = (mode_t'(bus.mode_in) == MODE_CHASE) ? ONE_HOT0 : '0;
            led_nxt      = pattern_nxt;
        end
    end
endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen: arithmetic model of elapsed time since load checked every cycle.
module tb_led_pattern_gen;
    localparam int N = 4;
    localparam int P = 4;
    localparam int S = 3;
    localparam int B = 3;
    localparam int DMAX = (1 << B) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    led_pattern_if #(.NUM_LEDS(N)) bus ();

    led_pattern_gen #(
        .NUM_LEDS(N), .PRESCALE(P), .STEP_TICKS(S), .PWM_BITS(B)
    ) dut (
        .clk_in(clk),
        .rst_n_in(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int t = 0;      // edges since the last load or reset
    int mmode = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int tri_duty(input int k);
        int m;
        m = k % (2 * DMAX);
        return (m <= DMAX) ? m : (2 * DMAX - m);
    endfunction

    function automatic logic [N-1:0] exp_led();
        logic [N-1:0] v;
        v = '0;
        case (mmode)
            1: v = N'((t / (P * S)) % (1 << N));
            2: v = N'(1 << ((t / (P * S)) % N));
            3: if (t > 0 && ((t - 1) % (1 << B)) < tri_duty((t - 1) / P)) v = '1;
            default: v = '0;
        endcase
        return v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t = 0;
            mmode = 0;
        end else if (bus.mode_load_in) begin
            t = 0;
            mmode = int'(bus.mode_in);
        end else begin
            t++;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("model_led", 32'(bus.led_out), 32'(exp_led()));
            check("model_tick", 32'(bus.tick_out), 32'((t % P) == (P - 1)));
            if (mmode == 2) check("chase_onehot", 32'($countones(bus.led_out)), 32'd1);
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load(input int m);
        bus.mode_in = 2'(m);
        bus.mode_load_in = 1'b1;
        @(posedge clk);
        #1;
        bus.mode_load_in = 1'b0;
    endtask

    initial begin
        bus.mode_in = 2'd0;
        bus.mode_load_in = 1'b0;
        #2;
        check("reset_led", 32'(bus.led_out), 32'd0);
        check("reset_tick", 32'(bus.tick_out), 32'd0);
        #10 rst_n = 1'b1;

        // idle OFF after release: first tick in cycle 4
        cyc(2);
        check("first_tick_early", 32'(bus.tick_out), 32'd0);
        cyc(1);
        check("first_tick", 32'(bus.tick_out), 32'd1);
        cyc(1);
        check("first_tick_end", 32'(bus.tick_out), 32'd0);
        cyc(10);

        // COUNT
        load(1);
        check("count_init", 32'(bus.led_out), 32'h0);
        cyc(11);
        check("count_hold", 32'(bus.led_out), 32'h0);
        cyc(1);
        check("count_1", 32'(bus.led_out), 32'h1);
        cyc(12);
        check("count_2", 32'(bus.led_out), 32'h2);
        cyc(156);
        check("count_15", 32'(bus.led_out), 32'hF);
        cyc(12);
        check("count_wrap", 32'(bus.led_out), 32'h0);

        // CHASE
        load(2);
        check("chase_init", 32'(bus.led_out), 32'h1);
        cyc(12);
        check("chase_1", 32'(bus.led_out), 32'h2);
        cyc(12);
        check("chase_2", 32'(bus.led_out), 32'h4);
        cyc(12);
        check("chase_3", 32'(bus.led_out), 32'h8);
        cyc(12);
        check("chase_wrap", 32'(bus.led_out), 32'h1);

        // BREATHE: duty 7 window, then descent and rise via the model
        load(3);
        check("breathe_init", 32'(bus.led_out), 32'h0);
        cyc(29);
        check("breathe_d7_on", 32'(bus.led_out), 32'hF);
        cyc(3);
        check("breathe_d7_off", 32'(bus.led_out), 32'h0);
        cyc(40);

        // CHASE load on the same edge as a COUNT step
        load(1);
        cyc(11);
        load(2);
        check("prio_chase_init", 32'(bus.led_out), 32'h1);
        cyc(11);
        check("prio_hold", 32'(bus.led_out), 32'h1);
        cyc(1);
        check("prio_step", 32'(bus.led_out), 32'h2);
        cyc(17);
        load(2);
        check("reload_chase", 32'(bus.led_out), 32'h1);
        cyc(5);

        // asynchronous reset in BREATHE with duty 5
        load(3);
        cyc(21);
        check("breathe_d5_on", 32'(bus.led_out), 32'hF);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_led", 32'(bus.led_out), 32'h0);
        check("async_rst_tick", 32'(bus.tick_out), 32'h0);
        #10 rst_n = 1'b1;
        cyc(2);
        check("post_rst_tick_early", 32'(bus.tick_out), 32'd0);
        cyc(1);
        check("post_rst_tick", 32'(bus.tick_out), 32'd1);
        cyc(27);
        check("post_rst_off", 32'(bus.led_out), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
